// File: rtl/inst_fetch_queue_if.sv
// Purpose : handshake and bus bundle for inst_fetch_queue. It groups the
//           fetch control, instruction-memory, decode-side and occupancy
//           signals into one interface.
// Modports: slave  - the fetch queue itself
//           master - the environment (execute stage, imem and decode)
// Signals : fetch_en, redirect, redirect_pc, imem_addr, imem_rdata,
//           out_valid, out_inst, out_pc, out_ready, count
interface inst_fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            fetch_en;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            out_valid;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;
  logic            out_ready;
  logic [CW-1:0]   count;

  modport slave (
    input  fetch_en, redirect, redirect_pc, imem_rdata, out_ready,
    output imem_addr, out_valid, out_inst, out_pc, count
  );

  modport master (
    output fetch_en, redirect, redirect_pc, imem_rdata, out_ready,
    input  imem_addr, out_valid, out_inst, out_pc, count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Purpose : instruction fetch queue. It generates the fetch PC and buffers
//           {instruction, pc} pairs in a circular FIFO. Decode drains the
//           FIFO through a valid/ready handshake. A redirect from EX flushes
//           every buffered entry and restarts fetch at the target address.
// Ports   : clk - rising-edge clock
//           rst - asynchronous reset, active low
//           bus - inst_fetch_queue_if.slave (fetch control, imem,
//                 decode handshake, occupancy count)
// Options : FQ_BYPASS_EN - when defined, an empty queue forwards
//           imem_rdata and fetch_pc straight to out_* (zero-cycle latency).
//           When undefined, out_* come from storage only.
module inst_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                rst,
  inst_fetch_queue_if.slave  bus
);
  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   cnt;

  logic empty;
  logic full;
  logic bypass;
  logic deq;
  logic fetch;
  logic push;
  logic pop;

  always_comb begin
    empty = (cnt == '0);
    full  = (cnt == FULL_CNT);
`ifdef FQ_BYPASS_EN
    bypass = empty & bus.fetch_en & ~bus.redirect;
`else
    bypass = 1'b0;
`endif
    deq   = (~empty | bypass) & bus.out_ready;
    // A full queue may still fetch when its head leaves in the same cycle.
    fetch = bus.fetch_en & ~bus.redirect & (~full | deq);
    // When a bypassed instruction is consumed directly, it never touches
    // storage, and no stored entry is popped.
    push  = fetch & ~(bypass & bus.out_ready);
    pop   = deq & ~bypass;
  end

  assign bus.imem_addr = fetch_pc;
  assign bus.count     = cnt;

`ifdef FQ_BYPASS_EN
  assign bus.out_valid = ~empty | bypass;
  assign bus.out_inst  = bypass ? bus.imem_rdata : inst_mem[rd_ptr];
  assign bus.out_pc    = bypass ? fetch_pc       : pc_mem[rd_ptr];
`else
  assign bus.out_valid = ~empty;
  assign bus.out_inst  = inst_mem[rd_ptr];
  assign bus.out_pc    = pc_mem[rd_ptr];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      // Cleared so an empty queue never presents X on out_inst/out_pc.
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (bus.redirect) begin
      // Flush takes priority. A same-cycle dequeue is dropped because the
      // consumer flushes on its own.
      fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
    end else begin
      if (fetch) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (push) begin
        inst_mem[wr_ptr] <= bus.imem_rdata;
        pc_mem[wr_ptr]   <= fetch_pc;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Purpose : self-checking bench for inst_fetch_queue. A queue-based
//           reference model tracks the expected buffered PCs and the fetch
//           PC. The instruction memory returns addr ^ 32'hA5A5_0000.
// Ports   : none (top-level bench). Honours FQ_BYPASS_EN like the design.
module tb_inst_fetch_queue;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] MAGIC    = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  inst_fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  inst_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_rdata = bus.imem_addr ^ MAGIC;

  // Reference model: PCs held in the queue, in order, plus the next fetch PC.
  logic [31:0] mq[$];
  logic [31:0] m_pc;

  function automatic bit m_bypass();
`ifdef FQ_BYPASS_EN
    return (mq.size() == 0) && bus.fetch_en && !bus.redirect;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_valid();
    return (mq.size() != 0) || m_bypass();
  endfunction

  function automatic logic [31:0] exp_pc();
    if (mq.size() != 0) return mq[0];
    return m_pc;
  endfunction

  function automatic logic [CW-1:0] exp_cnt();
    return CW'(mq.size());
  endfunction

  // Advance the model using the inputs applied for this cycle, then clock
  // the DUT and settle 1 time unit past the edge.
  task automatic tick();
    bit byp, d, e;
    int sz;
    if (bus.redirect) begin
      mq.delete();
      m_pc = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      byp = m_bypass();
      d   = exp_valid() && bus.out_ready;
      sz  = mq.size();
      e   = bus.fetch_en && ((sz < DEPTH) || d);
      if (d && !byp) void'(mq.pop_front());
      if (e) begin
        if (!(byp && bus.out_ready)) mq.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst             = 1'b0;
    bus.fetch_en    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = 1'b0;
    mq.delete();
    m_pc = RESET_PC;
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst             = 1'b0;
    bus.fetch_en    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = 1'b0;
    #2;
    n_checks++; if (bus.imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr got=%h exp=%h", bus.imem_addr, RESET_PC); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    n_checks++; if (bus.out_pc !== '0) begin n_fail++; $display("FAIL reset_out_pc got=%h exp=0", bus.out_pc); end
    n_checks++; if (bus.out_inst !== '0) begin n_fail++; $display("FAIL reset_out_inst got=%h exp=0", bus.out_inst); end
  endtask

  task automatic test_stream();
    do_reset();
    bus.fetch_en  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== exp_valid()) begin n_fail++; $display("FAIL stream_pre_valid got=%b exp=%b", bus.out_valid, exp_valid()); end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid cyc=%0d got=%b exp=1", i, bus.out_valid); end
      n_checks++; if (bus.out_pc !== exp_pc()) begin n_fail++; $display("FAIL stream_pc cyc=%0d got=%h exp=%h", i, bus.out_pc, exp_pc()); end
      n_checks++; if (bus.out_inst !== (exp_pc() ^ MAGIC)) begin n_fail++; $display("FAIL stream_inst cyc=%0d got=%h exp=%h", i, bus.out_inst, exp_pc() ^ MAGIC); end
      n_checks++; if (bus.count > 1) begin n_fail++; $display("FAIL stream_count cyc=%0d got=%0d exp<=1", i, bus.count); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.fetch_en  = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++; if (bus.count !== exp_cnt()) begin n_fail++; $display("FAIL fill_count cyc=%0d got=%0d exp=%0d", i, bus.count, exp_cnt()); end
      n_checks++; if (bus.imem_addr !== m_pc) begin n_fail++; $display("FAIL fill_addr cyc=%0d got=%h exp=%h", i, bus.imem_addr, m_pc); end
    end
    n_checks++; if (bus.count !== CW'(4)) begin n_fail++; $display("FAIL full_count got=%0d exp=4", bus.count); end
    n_checks++; if (bus.imem_addr !== 32'h10) begin n_fail++; $display("FAIL full_addr got=%h exp=10", bus.imem_addr); end
    n_checks++; if (bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL full_head got=%h exp=0", bus.out_pc); end
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.count !== CW'(4)) begin n_fail++; $display("FAIL full_enqdeq_count got=%0d exp=4", bus.count); end
    n_checks++; if (bus.out_pc !== 32'h4) begin n_fail++; $display("FAIL full_enqdeq_head got=%h exp=4", bus.out_pc); end
    bus.fetch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.out_pc !== exp_pc()) begin n_fail++; $display("FAIL drain_pc idx=%0d got=%h exp=%h", i, bus.out_pc, exp_pc()); end
      n_checks++; if (bus.out_inst !== (exp_pc() ^ MAGIC)) begin n_fail++; $display("FAIL drain_inst idx=%0d got=%h exp=%h", i, bus.out_inst, exp_pc() ^ MAGIC); end
      tick();
    end
    n_checks++; if (bus.count !== '0) begin n_fail++; $display("FAIL drain_count got=%0d exp=0", bus.count); end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.fetch_en  = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (bus.count !== CW'(3)) begin n_fail++; $display("FAIL redir_pre_count got=%0d exp=3", bus.count); end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h103;
    tick();
    bus.redirect = 1'b0;
    #1;
    n_checks++; if (bus.count !== '0) begin n_fail++; $display("FAIL redir_count got=%0d exp=0", bus.count); end
    n_checks++; if (bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr got=%h exp=100", bus.imem_addr); end
    n_checks++; if (bus.out_valid !== exp_valid()) begin n_fail++; $display("FAIL redir_valid got=%b exp=%b", bus.out_valid, exp_valid()); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL redir_target_valid got=%b exp=1", bus.out_valid); end
    n_checks++; if (bus.out_pc !== 32'h100) begin n_fail++; $display("FAIL redir_target_pc got=%h exp=100", bus.out_pc); end
  endtask

  task automatic test_redirect_deq_random();
    do_reset();
    bus.fetch_en  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    tick();
    bus.redirect    = 1'b1;
    bus.out_ready   = 1'b1;
    bus.redirect_pc = 32'h0000_2000;
    tick();
    bus.redirect  = 1'b0;
    bus.fetch_en  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    n_checks++; if (bus.count !== '0) begin n_fail++; $display("FAIL redir_deq_count got=%0d exp=0", bus.count); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_deq_valid got=%b exp=0", bus.out_valid); end
    for (int i = 0; i < 400; i++) begin
      bus.fetch_en    = ($urandom_range(0, 9) < 8);
      bus.out_ready   = ($urandom_range(0, 9) < 6);
      bus.redirect    = ($urandom_range(0, 19) == 0);
      bus.redirect_pc = $urandom();
      tick();
      n_checks++; if (bus.out_valid !== exp_valid()) begin n_fail++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, bus.out_valid, exp_valid()); end
      n_checks++; if (bus.count !== exp_cnt()) begin n_fail++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", i, bus.count, exp_cnt()); end
      n_checks++; if (bus.imem_addr !== m_pc) begin n_fail++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", i, bus.imem_addr, m_pc); end
      if (exp_valid()) begin
        n_checks++; if (bus.out_pc !== exp_pc()) begin n_fail++; $display("FAIL rand_pc cyc=%0d got=%h exp=%h", i, bus.out_pc, exp_pc()); end
        n_checks++; if (bus.out_inst !== (exp_pc() ^ MAGIC)) begin n_fail++; $display("FAIL rand_inst cyc=%0d got=%h exp=%h", i, bus.out_inst, exp_pc() ^ MAGIC); end
      end
    end
    bus.redirect = 1'b0;
  endtask

  task automatic test_fetch_en_reset();
    do_reset();
    bus.fetch_en  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.count !== CW'(2)) begin n_fail++; $display("FAIL halt_pre_count got=%0d exp=2", bus.count); end
    bus.fetch_en  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.imem_addr !== 32'h8) begin n_fail++; $display("FAIL halt_addr cyc=%0d got=%h exp=8", i, bus.imem_addr); end
      n_checks++; if (bus.count !== exp_cnt()) begin n_fail++; $display("FAIL halt_count cyc=%0d got=%0d exp=%0d", i, bus.count, exp_cnt()); end
    end
    n_checks++; if (bus.count !== '0) begin n_fail++; $display("FAIL halt_drained got=%0d exp=0", bus.count); end
    bus.fetch_en  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    tick();
    #1;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.imem_addr !== RESET_PC) begin n_fail++; $display("FAIL async_addr got=%h exp=%h", bus.imem_addr, RESET_PC); end
    n_checks++; if (bus.count !== '0) begin n_fail++; $display("FAIL async_count got=%0d exp=0", bus.count); end
    n_checks++; if (bus.out_pc !== '0) begin n_fail++; $display("FAIL async_out_pc got=%h exp=0", bus.out_pc); end
    bus.fetch_en = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid got=%b exp=0", bus.out_valid); end
    mq.delete();
    m_pc = RESET_PC;
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_deq_random();
    test_fetch_en_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
